seg7_bcd_updown_counter: RTL and testbench
==========================================

// Module: seg7_bcd_updown_counter
// PURPOSE
//   Parametrised N-digit BCD up/down counter with multiplexed 7-segment drive.
//   Generalises the fixed 4-digit up-only board counter: adds digit count, tick
//   and scan rates, direction, enable, parallel load and wrap flag.
//   Sits between board clock/reset and the 7-seg anode/cathode pins. Also
//   exports the BCD value to other logic.
// PARAMETERS
//   NUM_DIGITS  4            digits, 1..8; digit 0 is the rightmost (ones) digit
//   TICK_DIV    100_000_000  clk cycles per count step (>=2); 1 Hz at 100 MHz
//   SCAN_DIV    100_000      clk cycles per digit display slot (>=2); 1 kHz at 100 MHz
// PORTS
//   clk       in   1     system clock; all logic on rising edge
//   rst_n     in   1     asynchronous, active-low reset
//   en        in   1     1 = prescaler runs; 0 = prescaler and digits hold
//   up_dn     in   1     1 = count up, 0 = count down; sampled on the tick cycle
//   load      in   1     synchronous parallel load strobe
//   load_val  in   4*N   BCD load value; nibble k = digit k
//   count     out  4*N   current BCD value; nibble k = digit k
//   tick      out  1     1-cycle pulse when a count step is applied
//   wrap      out  1     1-cycle pulse on wrap (up: all-9 -> 0; down: 0 -> all-9)
//   an        out  N     anode selects, active-low, one-hot-low
//   seg       out  7     cathodes, active-low, {g,f,e,d,c,b,a}
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - prescaler = 0, scan counter = 0, scan index = 0, all digits = 0.
//   - tick = 0, wrap = 0, an = all 1, seg = 7'b1111111.
//   Prescaler:
//   - counts 0..TICK_DIV-1 while en = 1 and holds while en = 0.
//   - tick is registered. It is 1 in the cycle after the prescaler reaches
//     TICK_DIV-1 with en = 1. The digit update happens in that same cycle.
//   Count step:
//   - up: ripple BCD increment. A digit at 9 goes to 0 and carries into the
//     next digit. All-9 goes to all-0 and wrap = 1 for that cycle.
//   - down: ripple BCD decrement. A digit at 0 goes to 9 and borrows from the
//     next digit. All-0 goes to all-9 and wrap = 1 for that cycle.
//   Load:
//   - load has priority over the count step. On the next edge digits take
//     load_val, any nibble > 9 is clamped to 9, and the prescaler clears to 0.
//   - tick and wrap are 0 in the cycle a load is applied.
//   - a load in the same cycle as a pending tick drops that tick.
//   - load works regardless of en.
//   Scan:
//   - a free-running counter 0..SCAN_DIV-1 is unaffected by en and load.
//   - at SCAN_DIV-1 the scan index advances, N-1 wraps to 0.
//   - an and seg are registered together from the scan index and the current
//     digits. Latency is 1 cycle, so there is never a cycle where an and seg
//     disagree.
//   - digit values 10..15 cannot occur; the decoder default is blank.
//   Decode (active-low, g..a):
//   - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
//   - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
//   Mid-operation reset: rst_n low at any time forces all reset values
//   immediately, with no clk edge needed.
// CONFIGURATION
//   SEG7_LZ_BLANK_EN defined:
//   - leading-zero blanking. While digit k is selected, seg = 7'b1111111 if
//     k > 0 and digits k..N-1 are all 0. an still asserts normally.
//   - digit 0 is never blanked, so value 0 shows a single "0".
//   SEG7_LZ_BLANK_EN undefined: every digit is always decoded (zero-padded).
//   count, tick and wrap are identical in both builds.
// TESTING  (bench params: NUM_DIGITS=4, TICK_DIV=4, SCAN_DIV=3)
//   - Reset: rst_n=0 mid-count -> count=16'h0000, an=4'b1111,
//     seg=7'h7F, tick=0, wrap=0 with no clk edge.
//   - Up roll: load 16'h9998, up_dn=1, en=1 -> 2 ticks give 16'h9999 then
//     16'h0000. wrap=1 only on the second tick; ticks are 4 cycles apart.
//   - Down roll: load 16'h0001, up_dn=0 -> ticks give 16'h0000 then 16'h9999
//     with wrap=1; the next tick gives 16'h9998.
//   - Load/clamp/priority: load_val=16'h3A7F asserted on the tick cycle
//     -> count=16'h3979, tick=0, and the next tick comes 4 cycles after the load.
//   - en hold: en=0 for 20 cycles -> count and prescaler frozen, scan keeps
//     cycling an 1110->1101->1011->0111 every 3 cycles.
//   - Decode: count=16'h0070 -> slot0 seg=1000000, slot1 seg=1111000.
//     Slots 2 and 3 show 1000000, or 1111111 with SEG7_LZ_BLANK_EN.

Source files
------------

// File: rtl/seg7_bcd_updown_counter.sv
// seg7_bcd_updown_counter
//   N-digit BCD up/down counter with a prescaled count step, parallel load with
//   per-nibble clamping, a wrap flag and a multiplexed active-low 7-segment drive.
//   Build option: define SEG7_LZ_BLANK_EN to blank leading zero digits on the
//   display. count/tick/wrap behave identically in both builds.
module seg7_bcd_updown_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100_000_000,
  parameter int SCAN_DIV   = 100_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    tick,
  output logic                    wrap,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]           presc_reg;
  logic [4*NUM_DIGITS-1:0] digits_reg;
  logic                    tick_reg;
  logic                    wrap_reg;
  logic [SW-1:0]           scan_cnt_reg;
  logic [IW-1:0]           scan_idx_reg;
  logic [NUM_DIGITS-1:0]   an_reg;
  logic [6:0]              seg_reg;

  logic [4*NUM_DIGITS-1:0] inc_next;
  logic [4*NUM_DIGITS-1:0] dec_next;
  logic [4*NUM_DIGITS-1:0] clamp_next;
  logic                    carry_out;
  logic                    borrow_out;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              seg_next;
  logic                    blank;
  logic [3:0]              digit_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   digit_zero;

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes show blank.
  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = 7'b1111111;
    endcase
  endfunction

  // Per-digit views: array form for the scan mux, zero flags, clamped load nibbles.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_arr[gi]  = digits_reg[4*gi +: 4];
      assign digit_zero[gi] = (digits_reg[4*gi +: 4] == 4'd0);
      assign clamp_next[4*gi +: 4] = (load_val[4*gi +: 4] > 4'd9) ? 4'd9 : load_val[4*gi +: 4];
    end
  endgenerate

  // Ripple BCD increment and decrement of the whole digit vector.
  always_comb begin
    logic c;
    logic b;
    inc_next = digits_reg;
    dec_next = digits_reg;
    c = 1'b1;
    b = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (c) inc_next[4*k +: 4] = (digits_reg[4*k +: 4] == 4'd9) ? 4'd0 : digits_reg[4*k +: 4] + 4'd1;
      if (b) dec_next[4*k +: 4] = (digits_reg[4*k +: 4] == 4'd0) ? 4'd9 : digits_reg[4*k +: 4] - 4'd1;
      c = c & (digits_reg[4*k +: 4] == 4'd9);
      b = b & (digits_reg[4*k +: 4] == 4'd0);
    end
    carry_out  = c;
    borrow_out = b;
  end

  // Prescaler, count step and load; load wins and suppresses the step pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg  <= '0;
      digits_reg <= '0;
      tick_reg   <= 1'b0;
      wrap_reg   <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      wrap_reg <= 1'b0;
      if (load) begin
        digits_reg <= clamp_next;
        presc_reg  <= '0;
      end else if (en) begin
        if (presc_reg == PW'(TICK_DIV - 1)) begin
          presc_reg <= '0;
          tick_reg  <= 1'b1;
          if (up_dn) begin
            digits_reg <= inc_next;
            wrap_reg   <= carry_out;
          end else begin
            digits_reg <= dec_next;
            wrap_reg   <= borrow_out;
          end
        end else begin
          presc_reg <= presc_reg + PW'(1);
        end
      end
    end
  end

  // Display mux: anode and cathode for the currently selected digit.
  always_comb begin
    an_next = ~(NUM_DIGITS'(1) << scan_idx_reg);
    blank   = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
    // Blank when a non-ones digit and every more significant digit are zero.
    blank = (scan_idx_reg != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((k >= int'(scan_idx_reg)) && !digit_zero[k]) blank = 1'b0;
    end
`endif
    seg_next = blank ? 7'b1111111 : dec7(digit_arr[scan_idx_reg]);
  end

  // Free-running scan timer and index; an/seg registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_reg <= '0;
      scan_idx_reg <= '0;
      an_reg       <= '1;
      seg_reg      <= 7'b1111111;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      if (scan_cnt_reg == SW'(SCAN_DIV - 1)) begin
        scan_cnt_reg <= '0;
        scan_idx_reg <= (scan_idx_reg == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx_reg + IW'(1);
      end else begin
        scan_cnt_reg <= scan_cnt_reg + SW'(1);
      end
    end
  end

  assign count = digits_reg;
  assign tick  = tick_reg;
  assign wrap  = wrap_reg;
  assign an    = an_reg;
  assign seg   = seg_reg;

endmodule

// File: tb/tb_seg7_bcd_updown_counter.sv
// Directed bench for seg7_bcd_updown_counter (N=4, TICK_DIV=4, SCAN_DIV=3).
// Expected count/wrap per tick are queued when stimulus is applied and popped
// when the DUT pulses tick.
module tb_seg7_bcd_updown_counter;
  localparam int N  = 4;
  localparam int TD = 4;
  localparam int SD = 3;

  localparam logic [6:0] SEG_TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          up_dn = 1'b1;
  logic          load = 1'b0;
  logic [4*N-1:0] load_val = '0;
  logic [4*N-1:0] count;
  logic          tick;
  logic          wrap;
  logic [N-1:0]  an;
  logic [6:0]    seg;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [15:0] cnt;
    logic        wrp;
  } exp_t;
  exp_t sb_q[$];

  seg7_bcd_updown_counter #(.NUM_DIGITS(N), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(count), .tick(tick), .wrap(wrap),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] c, input logic w);
    exp_t e;
    e.cnt = c;
    e.wrp = w;
    sb_q.push_back(e);
  endtask

  task automatic do_load(input logic [15:0] v);
    load_val = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Wait for the next tick pulse (bounded), then check gap and scoreboard entry.
  task automatic tick_step(input string tag, input int gap);
    int n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 20);
    chk({tag, "_gap"}, n, gap);
    chk({tag, "_tick"}, tick, 1);
    e = sb_q.pop_front();
    chk({tag, "_count"}, count, e.cnt);
    chk({tag, "_wrap"}, wrap, e.wrp);
    $display("tick %s: count=%04h wrap=%0b after %0d cycles", tag, count, wrap, n);
  endtask

  // Load a value with counting stopped and check each display slot's cathodes.
  task automatic scan_check(input string tag, input logic [15:0] v);
    logic [3:0] seen;
    logic [3:0] dig;
    logic       blk;
    logic [6:0] exp_seg;
    do_load(v);
    @(negedge clk);
    chk({tag, "_count"}, count, v);
    seen = '0;
    repeat (14) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (an == ~(4'b0001 << k)) begin
          dig = v[4*k +: 4];
          blk = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
          blk = (k > 0) && ((v >> (4*k)) == 16'h0);
`endif
          exp_seg = blk ? 7'h7F : SEG_TBL[dig];
          if (!seen[k]) begin
            chk({tag, "_seg"}, seg, exp_seg);
            $display("scan %s: slot %0d an=%04b seg=%07b", tag, k, an, seg);
          end
          seen[k] = 1'b1;
        end
      end
    end
    chk({tag, "_slots_seen"}, seen, 4'hF);
  endtask

  initial begin
    logic [3:0] prev_an;
    int last_chg;
    int nchg;

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    chk("rst_count", count, 16'h0000);
    chk("rst_tick", tick, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    rst_n = 1'b1;

    // Up roll through all-9.
    en = 1'b1;
    up_dn = 1'b1;
    do_load(16'h9998);
    chk("up_load_count", count, 16'h9998);
    chk("up_load_tick", tick, 0);
    push_exp(16'h9999, 1'b0);
    push_exp(16'h0000, 1'b1);
    tick_step("up1", 4);
    tick_step("up2", 4);
    @(negedge clk);
    chk("up_pulse_tick", tick, 0);
    chk("up_pulse_wrap", wrap, 0);

    // Down roll through all-0.
    up_dn = 1'b0;
    do_load(16'h0001);
    push_exp(16'h0000, 1'b0);
    push_exp(16'h9999, 1'b1);
    push_exp(16'h9998, 1'b0);
    tick_step("dn1", 4);
    tick_step("dn2", 4);
    tick_step("dn3", 4);

    // Load with clamping on the cycle that would have produced a tick.
    up_dn = 1'b1;
    repeat (3) @(negedge clk);
    do_load(16'h3A7F);
    chk("ld_count", count, 16'h3979);
    chk("ld_tick", tick, 0);
    chk("ld_wrap", wrap, 0);
    push_exp(16'h3980, 1'b0);
    tick_step("ld1", 4);

    // Enable low: count and prescaler hold, scan keeps rotating.
    en = 1'b0;
    prev_an = an;
    last_chg = 0;
    nchg = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk("hold_count", count, 16'h3980);
      chk("hold_tick", tick, 0);
      if (an != prev_an) begin
        chk("hold_scan_seq", an, {prev_an[2:0], prev_an[3]});
        if (nchg > 0) chk("hold_scan_gap", c - last_chg, 3);
        nchg++;
        last_chg = c;
        prev_an = an;
      end
    end
    chk("hold_scan_moves", (nchg >= 6) ? 1 : 0, 1);
    en = 1'b1;
    push_exp(16'h3981, 1'b0);
    tick_step("resume", 4);

    // Decode across all digit values and leading-zero cases.
    en = 1'b0;
    scan_check("dec0070", 16'h0070);
    scan_check("dec3210", 16'h3210);
    scan_check("dec7654", 16'h7654);
    scan_check("dec1098", 16'h1098);

    // Asynchronous reset between clock edges.
    en = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 16'h0000);
    chk("arst_tick", tick, 0);
    chk("arst_wrap", wrap, 0);
    chk("arst_an", an, 4'hF);
    chk("arst_seg", seg, 7'h7F);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
